// File: rtl/sevseg_scan.sv
// Time-multiplexed driver for an eight-digit common-anode seven-segment display.
// Define SEVSEG_LZ_BLANK_EN to enable leading-zero suppression of digits 1..7.
module sevseg_scan #(
   parameter int DIV       = 100000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        en,
   input  logic [31:0] value,
   input  logic [7:0]  dp_mask,
   output logic [7:0]  an,
   output logic [6:0]  sev_out,
   output logic        dp,
   output logic        frame_done
);

   localparam int            PW      = $clog2(DIV);
   localparam logic [PW-1:0] P_LAST  = PW'(DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);

   logic [PW-1:0] p_q, p_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   frame_q, frame_d;
   logic          load_q, load_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    sev_q, sev_d;
   logic          dp_q, dp_d;
   logic          frame_done_q, frame_done_d;

   logic [3:0]    nibble;
   logic          lz_supp;
   logic          lit;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // Scan state: the frame snapshot is taken only as the last slot of digit 7 ends.
   always_comb begin
      // NOTE: defaults first so every path assigns every variable and no latch is inferred.
      p_d     = p_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      load_d  = 1'b0;
      if (en) begin
         if (p_q == P_LAST) begin
            p_d   = '0;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               frame_d = value;
               load_d  = 1'b1;
            end
         end else begin
            p_d = p_q + PW'(1);
         end
      end
   end

   always_comb begin
      nibble = frame_q[{idx_q, 2'b00} +: 4];
`ifdef SEVSEG_LZ_BLANK_EN
      lz_supp = (idx_q != 3'd0) && ((frame_q >> {idx_q, 2'b00}) == 32'd0);
`else
      lz_supp = 1'b0;
`endif
      lit          = en && (p_q >= P_BLANK) && !lz_supp;
      an_d         = lit ? ~(8'b1 << idx_q) : 8'hFF;
      sev_d        = lit ? seg_decode(nibble) : 7'h7F;
      dp_d         = lit ? ~dp_mask[idx_q] : 1'b1;
      frame_done_d = load_q & en;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         p_q          <= '0;
         idx_q        <= 3'd0;
         frame_q      <= 32'd0;
         load_q       <= 1'b0;
         an_q         <= 8'hFF;
         sev_q        <= 7'h7F;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         p_q          <= p_d;
         idx_q        <= idx_d;
         frame_q      <= frame_d;
         load_q       <= load_d;
         an_q         <= an_d;
         sev_q        <= sev_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign sev_out    = sev_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevseg_scan.sv
// Scoreboard bench for sevseg_scan (DIV=4, BLANK_CYC=1) against an arithmetic reference model.
module tb_sevseg_scan;

   localparam int DIV   = 4;
   localparam int BLANK = 1;
   localparam int FRAME = 8 * DIV;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] sev;
      logic       dp;
      logic       fd;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic [31:0] value;
   logic [7:0]  dp_mask;
   logic [7:0]  an;
   logic [6:0]  sev_out;
   logic        dp;
   logic        frame_done;

   logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   exp_t exp_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: count of enabled cycles within the frame plus the snapshot.
   int          n_en;
   logic [31:0] m_frame;
   logic        m_load_prev;

   sevseg_scan #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
      .clk        (clk),
      .Rst        (rst),
      .en         (en),
      .value      (value),
      .dp_mask    (dp_mask),
      .an         (an),
      .sev_out    (sev_out),
      .dp         (dp),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic suppressed(input int k, input logic [31:0] f);
`ifdef SEVSEG_LZ_BLANK_EN
      return (k >= 1) && ((f >> (4 * k)) == 32'd0);
`else
      return (k < 0) && (f == 32'd0);
`endif
   endfunction

   // Model: at each edge, predict the outputs registered from the pre-edge state.
   initial begin
      exp_t e;
      int   pos, m_p, m_idx;
      logic lit, load_now;
      n_en        = 0;
      m_frame     = 32'd0;
      m_load_prev = 1'b0;
      forever begin
         @(posedge clk);
         if (rst) begin
            n_en        = 0;
            m_frame     = 32'd0;
            m_load_prev = 1'b0;
            e           = '{an: 8'hFF, sev: 7'h7F, dp: 1'b1, fd: 1'b0};
         end else begin
            pos   = n_en;
            m_p   = pos % DIV;
            m_idx = pos / DIV;
            lit   = en && (m_p >= BLANK) && !suppressed(m_idx, m_frame);
            e.an  = lit ? ~(8'(1) << m_idx) : 8'hFF;
            e.sev = lit ? seg_tab[(m_frame >> (4 * m_idx)) & 32'hF] : 7'h7F;
            e.dp  = lit ? ~dp_mask[m_idx] : 1'b1;
            e.fd  = m_load_prev && en;
            load_now = en && (pos == FRAME - 1);
            if (en) n_en = (n_en + 1) % FRAME;
            if (load_now) m_frame = value;
            m_load_prev = load_now;
         end
         exp_q.push_back(e);
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an",         32'(an),         32'(e.an));
            check("sev_out",    32'(sev_out),    32'(e.sev));
            check("dp",         32'(dp),         32'(e.dp));
            check("frame_done", 32'(frame_done), 32'(e.fd));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Step until the next edge will see slot (idx, p); bounded by two frames.
   task automatic wait_slot(input int idx, input int p);
      int budget = 2 * FRAME + 2;
      while (n_en != idx * DIV + p && budget > 0) begin
         cycles(1);
         budget--;
      end
      check("wait_slot_timeout", 32'(budget > 0), 32'd1);
   endtask

   initial begin
      rst     = 1'b1;
      en      = 1'b1;
      value   = 32'h89ABCDEF;
      dp_mask = 8'h00;
      cycles(3);
      rst = 1'b0;
      cycles(3 * FRAME);

      wait_slot(3, 1);
      value = 32'h12345678;
      cycles(2 * FRAME);

      wait_slot(3, 2);
      en = 1'b0;
      cycles(10);
      en = 1'b1;
      cycles(FRAME + 8);

      dp_mask = 8'h01;
      cycles(FRAME + 8);

      value = 32'h000000A5;
      cycles(2 * FRAME + 4);
      value = 32'h00000000;
      cycles(2 * FRAME + 4);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(19, 0) == 0) value = $urandom;
         if ($urandom_range(9, 0) == 0) dp_mask = 8'($urandom);
         en = ($urandom_range(7, 0) != 0);
         cycles(1);
      end
      en = 1'b1;
      value = 32'h00F00300;
      cycles(2 * FRAME);

      wait_slot(5, 2);
      rst = 1'b1;
      #1;
      check("rst_an",         32'(an),         32'hFF);
      check("rst_sev_out",    32'(sev_out),    32'h7F);
      check("rst_dp",         32'(dp),         32'd1);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      cycles(2);
      rst = 1'b0;
      cycles(FRAME + 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sevseg_scan.md
# sevseg_scan

Time-multiplexed driver for the board's eight-digit, common-anode seven-segment display. It consumes the 32-bit `debug_output` word selected at top level and produces the active-low anode and segment pins, replacing the inline 7-seg logic in the top module. It adds three things that logic lacks:
- frame-coherent snapshotting, so a value never tears across digits;
- a per-digit anti-ghosting blank interval;
- an enable for freezing or darkening the display.

## Interface
Parameters:
- `DIV`, default 100000: `clk` cycles per digit slot. Must be ≥ 2.
- `BLANK_CYC`, default 16: cycles at the start of each slot with all anodes off. Must be < `DIV`.

Ports:
- `clk`  in  1  sole clock. One clock; reset is asynchronous and active-high.
- `Rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  scan enable. 0 = freeze the scan and darken the display.
- `value`  in  32  hex word to display. Digit k shows `value[4k+3:4k]`.
- `dp_mask`  in  8  bit k = 1 lights the decimal point on digit k. Sampled live, not snapshotted.
- `an`  out  8  anodes, active low. One-hot-low when lit.
- `sev_out`  out  7  segments {a,b,c,d,e,f,g}, active low. Bit 6 = a.
- `dp`  out  1  decimal point, active low.
- `frame_done`  out  1  one-cycle pulse when `frame` reloads.

## Operation
State:
- prescaler `p`, width `$clog2(DIV)`
- digit index `idx`, 3 bits
- 32-bit `frame` snapshot

Scan:
- When `en`=1, `p` increments each cycle.
- At `p`=DIV-1, `p` wraps to 0 and `idx` increments. `idx` wraps 7→0.
- At `p`=DIV-1 with `idx`=7, `frame` <= `value` and `frame_done` pulses. This is the only load point.
- A `value` change mid-frame is invisible until the next load.

Enable:
- When `en`=0, `p`, `idx` and `frame` hold, and `frame_done`=0.

Registered outputs (computed from current state):
- `an`:
  - 8'hFF if `en`=0, or `p` < BLANK_CYC, or the digit is suppressed (see Configuration);
  - otherwise ~(8'b1 << `idx`).
- `sev_out`:
  - the decode of `frame[4*idx+3 -: 4]`;
  - 7'h7F whenever `an` is 8'hFF.
- Decode, 0–F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- `dp`:
  - ~`dp_mask[idx]` when `an` is lit;
  - 1 otherwise.

Reset values:
- `p`=0, `idx`=0, `frame`=0.
- `an`=8'hFF, `sev_out`=7'h7F, `dp`=1, `frame_done`=0.

## Timing
- Outputs lag the state by one cycle and are glitch-free, driven directly from flops.
- Cycle 1 is the first rising edge after `Rst` falls with `en`=1.
  - Digit 0 is lit from cycle BLANK_CYC+1 through cycle DIV.
  - The first frame displays zeros.
  - `frame_done` is high in cycle 8·DIV+1. That frame shows the snapshotted value.
- Each digit is lit DIV−BLANK_CYC cycles per slot. Frame period is 8·DIV cycles.
- `en` deasserted at cycle t:
  - `an`=8'hFF from cycle t+1.
  - On reassertion the scan resumes at the same `p` and `idx`. No cycles are lost or repeated.
- `Rst` asserted mid-slot: all outputs go to their reset values immediately (asynchronous). Scan restarts at digit 0 after release.

## Configuration
Macro `SEVSEG_LZ_BLANK_EN`:
- Defined: leading-zero suppression. Digit k ≥ 1 is suppressed (`an` bit held high, `sev_out`=7'h7F, `dp`=1) when `frame[31:4k]` == 0. Digit 0 is never suppressed. Suppression is evaluated from `frame`, so it is frame-coherent.
- Undefined: all eight digits are always shown. No suppression logic is synthesized.

## Test plan
All scenarios use DIV=4, BLANK_CYC=1.
- Reset: assert `Rst` mid-slot on digit 5 → same cycle `an`=FF, `sev_out`=7F, `dp`=1, `frame_done`=0. After release, digit 0 is lit at cycle 2.
- `value`=32'h89ABCDEF:
  - frame 1 shows 0000001 on all digits;
  - after `frame_done` (cycle 33), digit 0 shows `an`=FE, `sev_out`=0111000;
  - digit 7 shows `an`=7F, `sev_out`=0000000;
  - each digit is lit 3 of every 4 cycles.
- Tearing: change `value` to 32'h12345678 during digit 3 → the rest of that frame keeps the old nibbles; the new value appears only after the next `frame_done`.
- Enable: deassert `en` for 10 cycles at `p`=2 of digit 3 → `an`=FF throughout; afterwards digit 3 completes its remaining cycle, then digit 4 starts. Frame period stretches by exactly 10.
- Decimal point: `dp_mask`=8'h01 → `dp`=0 only while `an`=FE, 1 during blank cycles and on other digits.
- With `SEVSEG_LZ_BLANK_EN`:
  - `value`=32'h000000A5 → only `an`=FE/FD ever go low;
  - `value`=0 → only digit 0 is lit, showing 0000001.
- Without the macro, all eight digits are lit in both cases.
